lcd_byte_writer: RTL and testbench

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_byte_writer_if.sv | 11 +
 rtl/lcd_delay_counter.sv | 25 ++
 rtl/lcd_byte_writer.sv | 159 +++++++++++++++
 tb/tb_lcd_byte_writer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit LCD byte writer: state encoding,
// power-on init nibble/delay table and the slow (clear/home) command codes.
package lcd_pkg;

  localparam int CNT_W = 20;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_NIB,
    S_IDLE,
    S_HI_SETUP,
    S_HI_PULSE,
    S_HI_GAP,
    S_LO_SETUP,
    S_LO_PULSE,
    S_POST_WAIT
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Index of the final wait in the init table (after the fourth nibble).
  localparam logic [2:0] INIT_LAST = 3'd4;

  function automatic logic [3:0] init_nibble(input logic [2:0] idx);
    logic [3:0] nib;
    nib = (idx == 3'd3) ? 4'h2 : 4'h3;
    return nib;
  endfunction

  function automatic cnt_t init_delay(input logic [2:0] idx);
    cnt_t dly;
    case (idx)
      3'd0:    dly = cnt_t'(750000);
      3'd1:    dly = cnt_t'(205000);
      3'd2:    dly = cnt_t'(5000);
      default: dly = cnt_t'(2000);
    endcase
    return dly;
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte-offer handshake between a host and the LCD byte writer.
interface lcd_byte_writer_if;
  logic       iValid;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;
  logic       oBusy;

  modport master (output iValid, iRS, iData, input oReady, oBusy);
  modport slave  (input iValid, iRS, iData, output oReady, oBusy);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable 20-bit down-counter; done is high whenever the count sits at zero.
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t value,
  input  logic enable,
  output logic done
);
  cnt_t count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (enable && count_reg != '0) begin
      count_reg <= count_reg - cnt_t'(1);
    end
  end

  assign done = (count_reg == '0);
endmodule

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780-style LCD as two 4-bit nibbles with E strobes.
// Define LCD_INIT_EN to include the power-on nibble init sequence.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int P_SETUP  = 2,
  parameter int P_EPULSE = 12,
  parameter int P_NIBGAP = 50,
  parameter int P_SHORT  = 2000,
  parameter int P_LONG   = 82000
) (
  input  logic              Clock,
  input  logic              Reset,
  lcd_byte_writer_if.slave  host,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [3:0]        SF_DATA
);
  // A state lasting N cycles loads N-1 on entry and leaves when the count hits 0.
  localparam cnt_t C_SETUP = cnt_t'(P_SETUP - 1);
  localparam cnt_t C_PULSE = cnt_t'(P_EPULSE - 1);
  localparam cnt_t C_GAP   = cnt_t'(P_NIBGAP - 1);
  localparam cnt_t C_SHORT = cnt_t'(P_SHORT - 1);
  localparam cnt_t C_LONG  = cnt_t'(P_LONG - 1);

  lcd_state_t state_reg;
  logic       ready_reg;
  logic       rs_reg;
  logic [7:0] data_reg;
  logic       accept;
  logic       cnt_load;
  logic       cnt_done;
  logic       cnt_enable;
  cnt_t       cnt_value;

`ifdef LCD_INIT_EN
  localparam lcd_state_t RESET_STATE = S_INIT_WAIT;
  logic [2:0] init_idx_reg;
  logic       init_armed_reg;
`else
  localparam lcd_state_t RESET_STATE = S_IDLE;
`endif

  assign accept      = host.iValid && ready_reg;
  assign host.oReady = ready_reg;
  assign host.oBusy  = ~ready_reg;
  assign LCD_RW      = 1'b0;
  assign cnt_enable  = (state_reg != S_IDLE);

  lcd_delay_counter u_delay (
    .clk    (Clock),
    .rst    (Reset),
    .load   (cnt_load),
    .value  (cnt_value),
    .enable (cnt_enable),
    .done   (cnt_done)
  );

  // Counter reload: the duration of whichever state is entered on this edge.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state_reg)
`ifdef LCD_INIT_EN
      S_INIT_WAIT: begin
        if (!init_armed_reg) begin
          cnt_load  = 1'b1;
          cnt_value = init_delay(init_idx_reg) - cnt_t'(1);
        end else if (cnt_done && init_idx_reg != INIT_LAST) begin
          cnt_load  = 1'b1;
          cnt_value = C_SETUP;
        end
      end
      S_INIT_NIB: if (cnt_done) begin
        cnt_load  = 1'b1;
        cnt_value = LCD_E ? init_delay(init_idx_reg + 3'd1) - cnt_t'(1) : C_PULSE;
      end
`endif
      S_IDLE:      if (accept)   begin cnt_load = 1'b1; cnt_value = C_SETUP; end
      S_HI_SETUP:  if (cnt_done) begin cnt_load = 1'b1; cnt_value = C_PULSE; end
      S_HI_PULSE:  if (cnt_done) begin cnt_load = 1'b1; cnt_value = C_GAP;   end
      S_HI_GAP:    if (cnt_done) begin cnt_load = 1'b1; cnt_value = C_SETUP; end
      S_LO_SETUP:  if (cnt_done) begin cnt_load = 1'b1; cnt_value = C_PULSE; end
      S_LO_PULSE:  if (cnt_done) begin
        cnt_load  = 1'b1;
        cnt_value = is_long_cmd(rs_reg, data_reg) ? C_LONG : C_SHORT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= RESET_STATE;
      ready_reg <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= '0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      SF_DATA   <= '0;
`ifdef LCD_INIT_EN
      init_idx_reg   <= '0;
      init_armed_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
`ifdef LCD_INIT_EN
        S_INIT_WAIT: begin
          if (!init_armed_reg) begin
            init_armed_reg <= 1'b1;
          end else if (cnt_done) begin
            if (init_idx_reg == INIT_LAST) begin
              state_reg <= S_IDLE;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= S_INIT_NIB;
              SF_DATA   <= init_nibble(init_idx_reg);
              LCD_RS    <= 1'b0;
            end
          end
        end
        // LCD_E doubles as the setup/pulse phase flag of an init nibble.
        S_INIT_NIB: if (cnt_done) begin
          if (!LCD_E) begin
            LCD_E <= 1'b1;
          end else begin
            LCD_E        <= 1'b0;
            init_idx_reg <= init_idx_reg + 3'd1;
            state_reg    <= S_INIT_WAIT;
          end
        end
`endif
        S_IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            ready_reg <= 1'b0;
            rs_reg    <= host.iRS;
            data_reg  <= host.iData;
            LCD_RS    <= host.iRS;
            SF_DATA   <= host.iData[7:4];
            state_reg <= S_HI_SETUP;
          end
        end
        S_HI_SETUP: if (cnt_done) begin LCD_E <= 1'b1; state_reg <= S_HI_PULSE; end
        S_HI_PULSE: if (cnt_done) begin LCD_E <= 1'b0; state_reg <= S_HI_GAP;   end
        S_HI_GAP:   if (cnt_done) begin
          SF_DATA   <= data_reg[3:0];
          state_reg <= S_LO_SETUP;
        end
        S_LO_SETUP:  if (cnt_done) begin LCD_E <= 1'b1; state_reg <= S_LO_PULSE;  end
        S_LO_PULSE:  if (cnt_done) begin LCD_E <= 1'b0; state_reg <= S_POST_WAIT; end
        S_POST_WAIT: if (cnt_done) begin ready_reg <= 1'b1; state_reg <= S_IDLE;  end
        default: state_reg <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: an E-pulse monitor feeds a queue that
// each scenario compares against nibble/timing expectations derived from the byte.
module tb_lcd_byte_writer;

  localparam int P_SETUP  = 2;
  localparam int P_EPULSE = 12;
  localparam int P_NIBGAP = 50;
  localparam int P_SHORT  = 2000;
  localparam int P_LONG   = 82000;

  typedef struct {
    int         rise;
    int         fall;
    logic [3:0] nib;
    logic       rs;
  } pulse_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] sf_data;

  int     checks   = 0;
  int     fails    = 0;
  int     cyc      = 0;
  int     stab_err = 0;
  logic   e_prev   = 1'b0;
  pulse_t cur;
  pulse_t pulses[$];

  always #5 Clock = ~Clock;

  lcd_byte_writer_if bus ();

  lcd_byte_writer #(
    .P_SETUP  (P_SETUP),
    .P_EPULSE (P_EPULSE),
    .P_NIBGAP (P_NIBGAP),
    .P_SHORT  (P_SHORT),
    .P_LONG   (P_LONG)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .host    (bus),
    .LCD_E   (lcd_e),
    .LCD_RS  (lcd_rs),
    .LCD_RW  (lcd_rw),
    .SF_DATA (sf_data)
  );

  // Records every complete E pulse and counts data/RS changes while E is high
  // or in the first cycle after it falls.
  initial begin : monitor
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
        e_prev = 1'b0;
      end else begin
        if (lcd_e && !e_prev) begin
          cur.rise = cyc;
          cur.nib  = sf_data;
          cur.rs   = lcd_rs;
        end else if (lcd_e && (sf_data !== cur.nib || lcd_rs !== cur.rs)) begin
          stab_err++;
        end else if (!lcd_e && e_prev) begin
          cur.fall = cyc;
          pulses.push_back(cur);
          if (sf_data !== cur.nib || lcd_rs !== cur.rs) stab_err++;
        end
        e_prev = lcd_e;
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  function automatic int post_cycles(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_LONG : P_SHORT;
  endfunction

  // One complete byte: offer, accept, then check both nibbles and all timing.
  task automatic run_byte(input logic rs, input logic [7:0] d, input string tag);
    int base, st0, acc, rdy, n, exp_post;
    pulse_t p0, p1;
    base = pulses.size();
    st0 = stab_err;
    exp_post = post_cycles(rs, d);
    n = 0;
    while (bus.oReady !== 1'b1 && n < 5000) begin tick(); n++; end
    checks++;
    if (bus.oReady !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_offer: got %b want 1", tag, bus.oReady);
      return;
    end
    bus.iValid = 1'b1; bus.iRS = rs; bus.iData = d;
    tick();
    acc = cyc;
    bus.iValid = 1'b0; bus.iRS = 1'($urandom); bus.iData = 8'($urandom);
    checks++;
    if (bus.oReady !== 1'b0 || bus.oBusy !== 1'b1) begin
      fails++;
      $display("FAIL %s accept_drop: got ready=%b busy=%b want 0/1", tag, bus.oReady, bus.oBusy);
    end
    n = 0;
    while (bus.oReady !== 1'b1 && n < P_LONG + 200) begin tick(); n++; end
    rdy = cyc;
    checks++;
    if (bus.oReady !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_timeout: got %b want 1", tag, bus.oReady);
      return;
    end
    checks++;
    if (pulses.size() - base !== 2) begin
      fails++;
      $display("FAIL %s pulse_count: got %0d want 2", tag, pulses.size() - base);
      return;
    end
    p0 = pulses[base];
    p1 = pulses[base + 1];
    checks++;
    if ({p0.nib, p1.nib} !== d) begin
      fails++;
      $display("FAIL %s nibbles: got %h,%h want %h,%h", tag, p0.nib, p1.nib, d[7:4], d[3:0]);
    end
    checks++;
    if (p0.rs !== rs || p1.rs !== rs) begin
      fails++;
      $display("FAIL %s rs: got %b,%b want %b", tag, p0.rs, p1.rs, rs);
    end
    checks++;
    if (p0.fall - p0.rise !== P_EPULSE || p1.fall - p1.rise !== P_EPULSE) begin
      fails++;
      $display("FAIL %s e_width: got %0d,%0d want %0d", tag, p0.fall - p0.rise,
               p1.fall - p1.rise, P_EPULSE);
    end
    checks++;
    if (p0.rise - acc !== P_SETUP || p1.rise - p0.fall !== P_NIBGAP + P_SETUP) begin
      fails++;
      $display("FAIL %s spacing: got setup=%0d gap=%0d want %0d/%0d", tag, p0.rise - acc,
               p1.rise - p0.fall, P_SETUP, P_NIBGAP + P_SETUP);
    end
    checks++;
    if (rdy - p1.fall !== exp_post) begin
      fails++;
      $display("FAIL %s post_wait: got %0d want %0d", tag, rdy - p1.fall, exp_post);
    end
    checks++;
    if (stab_err !== st0 || bus.oBusy !== 1'b0) begin
      fails++;
      $display("FAIL %s stability_busy: got errs=%0d busy=%b want 0/0", tag, stab_err - st0, bus.oBusy);
    end
    $display("txn %s rs=%b data=%h post=%0d", tag, rs, d, rdy - p1.fall);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.iValid = 1'b0; bus.iRS = 1'b0; bus.iData = 8'h00;
    repeat (3) tick();
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, sf_data} !== 7'b0) begin
      fails++;
      $display("FAIL reset_lcd_pins: got e=%b rs=%b rw=%b data=%h want all 0", lcd_e, lcd_rs, lcd_rw, sf_data);
    end
    checks++;
    if (bus.oReady !== 1'b0 || bus.oBusy !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake: got ready=%b busy=%b want 0/1", bus.oReady, bus.oBusy);
    end
    Reset = 1'b0;
    tick();
    checks++;
`ifdef LCD_INIT_EN
    if (bus.oReady !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 0", bus.oReady);
    end
`else
    if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: got ready=%b busy=%b want 1/0", bus.oReady, bus.oBusy);
    end
`endif
    $display("txn reset released ready=%b", bus.oReady);
  endtask

`ifdef LCD_INIT_EN
  task automatic test_init();
    int base, start, n, rdy;
    int exp_rise[4] = '{750000, 955000, 960000, 962000};
    logic [3:0] exp_nib[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    logic early_ready;
    base = pulses.size();
    start = cyc;
    early_ready = 1'b0;
    n = 0;
    while (pulses.size() < base + 4 && n < 1000000) begin
      tick(); n++;
      if (bus.oReady === 1'b1) early_ready = 1'b1;
    end
    checks++;
    if (pulses.size() - base !== 4 || early_ready) begin
      fails++;
      $display("FAIL init_pulses: got %0d pulses early_ready=%b want 4/0", pulses.size() - base, early_ready);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pulses[base + k].nib !== exp_nib[k] || pulses[base + k].rs !== 1'b0 ||
          pulses[base + k].rise - start < exp_rise[k] ||
          pulses[base + k].rise - start > exp_rise[k] + 64) begin
        fails++;
        $display("FAIL init_nib%0d: got nib=%h rs=%b at %0d want %h/0 near %0d", k,
                 pulses[base + k].nib, pulses[base + k].rs, pulses[base + k].rise - start,
                 exp_nib[k], exp_rise[k]);
      end
    end
    n = 0;
    while (bus.oReady !== 1'b1 && n < 5000) begin tick(); n++; end
    rdy = cyc;
    checks++;
    if (rdy - pulses[base + 3].fall < 2000 || rdy - pulses[base + 3].fall > 2004) begin
      fails++;
      $display("FAIL init_final_wait: got %0d want ~2000", rdy - pulses[base + 3].fall);
    end
    $display("txn init done at cycle %0d", rdy - start);
  endtask
`endif

  task automatic test_char_write();
    run_byte(1'b1, 8'h41, "char_41");
  endtask

  task automatic test_long_cmd();
    run_byte(1'b0, 8'h01, "cmd_clear");
  endtask

  task automatic test_random();
    logic rs;
    logic [7:0] d;
    rs = 1'($urandom);
    d = 8'($urandom);
    // Keep this one short so the run stays within its cycle budget.
    if (!rs && d inside {8'h01, 8'h02, 8'h03}) d = d | 8'h80;
    run_byte(rs, d, "random");
  endtask

  task automatic test_back_to_back();
    int base, n, n_acc;
    logic was_ready;
    logic [3:0] exp_nib[4] = '{4'h4, 4'h8, 4'h4, 4'h9};
    base = pulses.size();
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'h48;
    n = 0; n_acc = 0;
    while (n_acc < 2 && n < 3 * (P_SHORT + 200)) begin
      was_ready = bus.oReady;
      tick(); n++;
      if (was_ready === 1'b1) begin
        n_acc++;
        bus.iData = 8'h49;
      end
    end
    bus.iValid = 1'b0;
    checks++;
    if (n_acc !== 2) begin
      fails++;
      $display("FAIL b2b_accepts: got %0d want 2", n_acc);
    end
    n = 0;
    while (bus.oReady !== 1'b1 && n < P_SHORT + 200) begin tick(); n++; end
    repeat (5) tick();
    checks++;
    if (pulses.size() - base !== 4) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d want 4", pulses.size() - base);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pulses[base + k].nib !== exp_nib[k] || pulses[base + k].rs !== 1'b1) begin
        fails++;
        $display("FAIL b2b_nib%0d: got %h rs=%b want %h rs=1", k, pulses[base + k].nib,
                 pulses[base + k].rs, exp_nib[k]);
      end
    end
    $display("txn back_to_back 48,49 pulses=%0d", pulses.size() - base);
  endtask

  task automatic test_busy_ignore();
    int base, n, rdy;
    logic [7:0] d;
    d = 8'($urandom);
    n = 0;
    while (bus.oReady !== 1'b1 && n < 5000) begin tick(); n++; end
    base = pulses.size();
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = d;
    tick();
    bus.iValid = 1'b0;
    n = 0;
    while (pulses.size() < base + 2 && n < 200) begin tick(); n++; end
    repeat (3) begin
      bus.iValid = 1'b1; bus.iRS = 1'($urandom); bus.iData = 8'($urandom);
      tick(); tick();
      bus.iValid = 1'b0;
      tick();
    end
    n = 0;
    while (bus.oReady !== 1'b1 && n < P_SHORT + 200) begin tick(); n++; end
    rdy = cyc;
    repeat (20) tick();
    checks++;
    if (pulses.size() - base !== 2 || bus.oReady !== 1'b1) begin
      fails++;
      $display("FAIL busy_ignore_pulses: got %0d pulses ready=%b want 2/1", pulses.size() - base, bus.oReady);
      return;
    end
    checks++;
    if (rdy - pulses[base + 1].fall !== P_SHORT ||
        {pulses[base].nib, pulses[base + 1].nib} !== d) begin
      fails++;
      $display("FAIL busy_ignore_byte: got post=%0d data=%h%h want %0d/%h",
               rdy - pulses[base + 1].fall, pulses[base].nib, pulses[base + 1].nib, P_SHORT, d);
    end
    $display("txn busy_ignore data=%h pulses=%0d", d, pulses.size() - base);
  endtask

  task automatic test_reset_mid_pulse();
    int base, n;
    n = 0;
    while (bus.oReady !== 1'b1 && n < 5000) begin tick(); n++; end
    bus.iValid = 1'b1; bus.iRS = 1'b1; bus.iData = 8'($urandom);
    tick();
    bus.iValid = 1'b0;
    n = 0;
    while (lcd_e !== 1'b1 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (lcd_e !== 1'b1) begin
      fails++;
      $display("FAIL midrst_in_pulse: got e=%b want 1", lcd_e);
    end
    base = pulses.size();
    Reset = 1'b1;
    #1;
    checks++;
    if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || sf_data !== 4'h0) begin
      fails++;
      $display("FAIL midrst_async: got e=%b rs=%b data=%h want 0/0/0", lcd_e, lcd_rs, sf_data);
    end
    checks++;
    if (bus.oReady !== 1'b0 || bus.oBusy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_handshake: got ready=%b busy=%b want 0/1", bus.oReady, bus.oBusy);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
`ifdef LCD_INIT_EN
    if (bus.oReady !== 1'b0) begin
`else
    if (bus.oReady !== 1'b1) begin
`endif
      fails++;
      $display("FAIL midrst_restart_state: got ready=%b", bus.oReady);
    end
    repeat (30) tick();
    checks++;
    if (pulses.size() !== base || lcd_e !== 1'b0) begin
      fails++;
      $display("FAIL midrst_no_resume: got %0d new pulses e=%b want 0/0", pulses.size() - base, lcd_e);
    end
    $display("txn reset_mid_pulse ready=%b", bus.oReady);
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_EN
    test_init();
`endif
    test_char_write();
    test_long_cmd();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
